// File: rtl/idu_queue.sv
// Instruction decode queue: a DEPTH-entry {pc, instr} FIFO whose head is decoded
// combinationally and captured into one registered output stage.
module idu_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_imm,
  output logic [4:0]                 out_rs1,
  output logic [4:0]                 out_rs2,
  output logic [4:0]                 out_rd,
  output logic [2:0]                 out_func3,
  output logic                       out_rs1_en,
  output logic                       out_rs2_en,
  output logic                       out_rd_wen,
  output logic                       out_op2_is_imm,
  output logic                       out_word,
  output logic                       out_illegal,
  output logic [6:0]                 out_class,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH+1);
  localparam bit IS32 = (XLEN == 32);

  localparam logic [6:0] CLS_ALU    = 7'b0000001;
  localparam logic [6:0] CLS_LOAD   = 7'b0000010;
  localparam logic [6:0] CLS_STORE  = 7'b0000100;
  localparam logic [6:0] CLS_BRANCH = 7'b0001000;
  localparam logic [6:0] CLS_JUMP   = 7'b0010000;
  localparam logic [6:0] CLS_CSR    = 7'b0100000;
  localparam logic [6:0] CLS_SYS    = 7'b1000000;

  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [31:0]     instr_mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;

  logic        push_s;
  logic        pop_s;
  logic [31:0] h_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [63:0] imm_s;
  logic [6:0]  cls_s;
  logic        ill_s;
  logic        rs1_en_s;
  logic        rs2_en_s;
  logic        wen_s;
  logic        op2_imm_s;
  logic        word_s;
  logic        f7_bad_s;

  assign in_ready = (count < CW'(DEPTH)) & ~flush;
  assign push_s   = in_valid & in_ready;
  // The output stage refills whenever it is empty or being consumed this edge.
  assign pop_s    = (count != CW'(0)) & (~out_valid | out_ready) & ~flush;

  assign h_s      = instr_mem_r[rd_ptr_r];
  assign f3_s     = h_s[14:12];
  assign f7_s     = h_s[31:25];
  assign f7_bad_s = (f7_s != 7'b0000000) & (f7_s != 7'b0100000);

  // FIFO storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= in_pc;
      instr_mem_r[wr_ptr_r] <= in_instr;
    end
  end

  // Head decode: raw per-opcode attributes; illegal and rd==0 masking applied below.
  always_comb begin
    imm_s     = 64'd0;
    cls_s     = 7'd0;
    ill_s     = 1'b0;
    rs1_en_s  = 1'b0;
    rs2_en_s  = 1'b0;
    wen_s     = 1'b0;
    op2_imm_s = 1'b0;
    word_s    = 1'b0;
    if (h_s[1:0] != 2'b11) begin
      ill_s = 1'b1;
    end else begin
      case (h_s[6:0])
        7'b0110111, 7'b0010111: begin
          cls_s = CLS_ALU; imm_s = {{32{h_s[31]}}, h_s[31:12], 12'd0};
          op2_imm_s = 1'b1; wen_s = 1'b1;
        end
        7'b1101111: begin
          cls_s = CLS_JUMP; op2_imm_s = 1'b1; wen_s = 1'b1;
          imm_s = {{43{h_s[31]}}, h_s[31], h_s[19:12], h_s[20], h_s[30:21], 1'b0};
        end
        7'b1100111: begin
          cls_s = CLS_JUMP; imm_s = {{52{h_s[31]}}, h_s[31:20]};
          rs1_en_s = 1'b1; op2_imm_s = 1'b1; wen_s = 1'b1;
        end
        7'b1100011: begin
          cls_s = CLS_BRANCH; rs1_en_s = 1'b1; rs2_en_s = 1'b1;
          imm_s = {{51{h_s[31]}}, h_s[31], h_s[7], h_s[30:25], h_s[11:8], 1'b0};
        end
        7'b0000011: begin
          ill_s = IS32 & ((f3_s == 3'b011) | (f3_s == 3'b110));
          cls_s = CLS_LOAD; imm_s = {{52{h_s[31]}}, h_s[31:20]};
          rs1_en_s = 1'b1; op2_imm_s = 1'b1; wen_s = 1'b1;
        end
        7'b0100011: begin
          ill_s = IS32 & (f3_s == 3'b011);
          cls_s = CLS_STORE; imm_s = {{52{h_s[31]}}, h_s[31:25], h_s[11:7]};
          rs1_en_s = 1'b1; rs2_en_s = 1'b1; op2_imm_s = 1'b1;
        end
        7'b0010011: begin
          // RV32 has only 5-bit shift amounts, so shamt[5] set is illegal there.
          ill_s = IS32 & (f3_s[1:0] == 2'b01) & h_s[25];
          cls_s = CLS_ALU; imm_s = {{52{h_s[31]}}, h_s[31:20]};
          rs1_en_s = 1'b1; op2_imm_s = 1'b1; wen_s = 1'b1;
        end
        7'b0011011: begin
          ill_s = IS32;
          cls_s = CLS_ALU; imm_s = {{52{h_s[31]}}, h_s[31:20]};
          rs1_en_s = 1'b1; op2_imm_s = 1'b1; wen_s = 1'b1; word_s = 1'b1;
        end
        7'b0110011: begin
          ill_s = f7_bad_s;
          cls_s = CLS_ALU; rs1_en_s = 1'b1; rs2_en_s = 1'b1; wen_s = 1'b1;
        end
        7'b0111011: begin
          ill_s = IS32 | f7_bad_s;
          cls_s = CLS_ALU; rs1_en_s = 1'b1; rs2_en_s = 1'b1; wen_s = 1'b1; word_s = 1'b1;
        end
        7'b0001111: begin
          cls_s = CLS_SYS;
        end
        7'b1110011: begin
          if (f3_s == 3'b000) begin
            cls_s = CLS_SYS;
          end else if (f3_s[2]) begin
            cls_s = CLS_CSR; wen_s = 1'b1; imm_s = {59'd0, h_s[19:15]};
          end else begin
            cls_s = CLS_CSR; wen_s = 1'b1; rs1_en_s = 1'b1;
          end
        end
        default: begin
          ill_s = 1'b1;
        end
      endcase
    end
  end

  // Queue pointers, occupancy and output-valid control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count <= count + CW'(push_s) - CW'(pop_s);
      if (pop_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

  // Registered decode outputs; only reloaded on a pop so they hold under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc         <= '0;
      out_imm        <= '0;
      out_rs1        <= 5'd0;
      out_rs2        <= 5'd0;
      out_rd         <= 5'd0;
      out_func3      <= 3'd0;
      out_rs1_en     <= 1'b0;
      out_rs2_en     <= 1'b0;
      out_rd_wen     <= 1'b0;
      out_op2_is_imm <= 1'b0;
      out_word       <= 1'b0;
      out_illegal    <= 1'b0;
      out_class      <= 7'd0;
    end else if (pop_s) begin
      out_pc         <= pc_mem_r[rd_ptr_r];
      out_imm        <= ill_s ? '0 : imm_s[XLEN-1:0];
      out_rs1        <= h_s[19:15];
      out_rs2        <= h_s[24:20];
      out_rd         <= h_s[11:7];
      out_func3      <= f3_s;
      out_rs1_en     <= ~ill_s & rs1_en_s;
      out_rs2_en     <= ~ill_s & rs2_en_s;
      out_rd_wen     <= ~ill_s & wen_s & (h_s[11:7] != 5'd0);
      out_op2_is_imm <= ~ill_s & op2_imm_s;
      out_word       <= ~ill_s & word_s;
      out_illegal    <= ill_s;
      out_class      <= ill_s ? 7'd0 : cls_s;
    end else begin
      out_pc         <= out_pc;
      out_imm        <= out_imm;
      out_rs1        <= out_rs1;
      out_rs2        <= out_rs2;
      out_rd         <= out_rd;
      out_func3      <= out_func3;
      out_rs1_en     <= out_rs1_en;
      out_rs2_en     <= out_rs2_en;
      out_rd_wen     <= out_rd_wen;
      out_op2_is_imm <= out_op2_is_imm;
      out_word       <= out_word;
      out_illegal    <= out_illegal;
      out_class      <= out_class;
    end
  end

endmodule

// File: tb/tb_idu_queue.sv
// Bench for idu_queue: directed scenarios plus random traffic checked against a
// queue-based reference model with a format-driven RISC-V decode.
module tb_idu_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [31:0] in_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_func3;
  logic        out_rs1_en, out_rs2_en, out_rd_wen, out_op2_is_imm, out_word, out_illegal;
  logic [6:0]  out_class;
  logic [2:0]  count;

  logic        v32, rdy32, ir32, ov32;
  logic [31:0] pc32, instr32, opc32, oimm32;
  logic [4:0]  rs1_32, rs2_32, rd_32;
  logic [2:0]  f3_32, cnt32;
  logic        e1_32, e2_32, wen32, op2_32, word32, ill32;
  logic [6:0]  cls32;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int base;

  typedef struct packed {logic [63:0] pc; logic [31:0] instr;} ent_t;
  typedef struct packed {
    logic [63:0] imm; logic [6:0] cls;
    logic ill, rs1, rs2, wen, op2, word;
  } dec_t;
  typedef enum {F_R, F_I, F_S, F_B, F_U, F_J, F_Z, F_C, F_N} fmt_t;

  ent_t q[$];
  ent_t oe;
  bit   ov = 1'b0;

  always #5 clk = ~clk;

  idu_queue #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_func3(out_func3), .out_rs1_en(out_rs1_en),
    .out_rs2_en(out_rs2_en), .out_rd_wen(out_rd_wen), .out_op2_is_imm(out_op2_is_imm),
    .out_word(out_word), .out_illegal(out_illegal), .out_class(out_class), .count(count)
  );

  idu_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v32), .in_ready(ir32),
    .in_pc(pc32), .in_instr(instr32), .out_valid(ov32), .out_ready(rdy32),
    .out_pc(opc32), .out_imm(oimm32), .out_rs1(rs1_32), .out_rs2(rs2_32),
    .out_rd(rd_32), .out_func3(f3_32), .out_rs1_en(e1_32), .out_rs2_en(e2_32),
    .out_rd_wen(wen32), .out_op2_is_imm(op2_32), .out_word(word32),
    .out_illegal(ill32), .out_class(cls32), .count(cnt32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: classify by instruction format, then build fields arithmetically.
  function automatic dec_t ref_dec(input logic [31:0] ins, input bit x32);
    dec_t   d;
    fmt_t   fmt;
    longint si;
    logic [2:0] f3;
    logic [6:0] f7;
    bit     bad7;
    d    = '0;
    fmt  = F_N;
    f3   = ins[14:12];
    f7   = ins[31:25];
    bad7 = !(f7 == 7'd0 || f7 == 7'd32);
    si   = longint'($signed(ins));
    if (ins[1:0] != 2'b11) d.ill = 1'b1;
    else begin
      case (ins[6:0])
        7'h37, 7'h17: begin fmt = F_U; d.cls = 7'd1; end
        7'h6F: begin fmt = F_J; d.cls = 7'd16; end
        7'h67: begin fmt = F_I; d.cls = 7'd16; end
        7'h63: begin fmt = F_B; d.cls = 7'd8; end
        7'h03: begin fmt = F_I; d.cls = 7'd2; d.ill = x32 && (f3 == 3'd3 || f3 == 3'd6); end
        7'h23: begin fmt = F_S; d.cls = 7'd4; d.ill = x32 && (f3 == 3'd3); end
        7'h13: begin fmt = F_I; d.cls = 7'd1; d.ill = x32 && (f3 == 3'd1 || f3 == 3'd5) && ins[25]; end
        7'h1B: begin fmt = F_I; d.cls = 7'd1; d.word = 1'b1; d.ill = x32; end
        7'h33: begin fmt = F_R; d.cls = 7'd1; d.ill = bad7; end
        7'h3B: begin fmt = F_R; d.cls = 7'd1; d.word = 1'b1; d.ill = x32 || bad7; end
        7'h0F: begin fmt = F_N; d.cls = 7'd64; end
        7'h73: begin
          if (f3 == 3'd0) begin fmt = F_N; d.cls = 7'd64; end
          else if (f3[2]) begin fmt = F_Z; d.cls = 7'd32; end
          else begin fmt = F_C; d.cls = 7'd32; end
        end
        default: d.ill = 1'b1;
      endcase
    end
    case (fmt)
      F_I: d.imm = si >>> 20;
      F_S: d.imm = ((si >>> 25) << 5) | longint'(ins[11:7]);
      F_B: d.imm = ((si >>> 31) << 12) | (longint'(ins[7]) << 11) | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      F_U: d.imm = (si >>> 12) << 12;
      F_J: d.imm = ((si >>> 31) << 20) | (longint'(ins[19:12]) << 12) | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      F_Z: d.imm = longint'(ins[19:15]);
      default: d.imm = 64'd0;
    endcase
    d.rs1 = fmt inside {F_I, F_S, F_B, F_R, F_C};
    d.rs2 = fmt inside {F_R, F_S, F_B};
    d.op2 = fmt inside {F_I, F_S, F_U, F_J};
    d.wen = !(fmt inside {F_S, F_B, F_N}) && (ins[11:7] != 5'd0);
    if (d.ill) d = '{imm: 64'd0, cls: 7'd0, ill: 1'b1, rs1: 1'b0, rs2: 1'b0, wen: 1'b0, op2: 1'b0, word: 1'b0};
    return d;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    case ($urandom_range(0, 14))
      0: ins[6:0] = 7'h37;   1: ins[6:0] = 7'h17;   2: ins[6:0] = 7'h6F;
      3: ins[6:0] = 7'h67;   4: ins[6:0] = 7'h63;   5: ins[6:0] = 7'h03;
      6: ins[6:0] = 7'h23;   7: ins[6:0] = 7'h13;   8: ins[6:0] = 7'h1B;
      9: ins[6:0] = 7'h33;  10: ins[6:0] = 7'h3B;  11: ins[6:0] = 7'h0F;
      12: ins[6:0] = 7'h73; 13: ins[6:0] = 7'h7F;
      default: ins = ins;
    endcase
    if ((ins[6:0] == 7'h33 || ins[6:0] == 7'h3B) && $urandom_range(0, 3) != 0)
      ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  // One clock: compare DUT with the model, advance the model, cross the edge.
  task automatic cycle();
    dec_t d;
    bit   do_load, accept;
    #1;
    if (!rst_n) begin q.delete(); ov = 1'b0; end
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !flush));
    check("out_valid", 64'(out_valid), 64'(ov));
    if (!rst_n) begin
      check("rst_pc", out_pc, 64'd0);
      check("rst_imm", out_imm, 64'd0);
      check("rst_rd", 64'(out_rd), 64'd0);
      check("rst_class", 64'(out_class), 64'd0);
      check("rst_wen", 64'(out_rd_wen), 64'd0);
    end else if (ov) begin
      d = ref_dec(oe.instr, 1'b0);
      check("pc", out_pc, oe.pc);
      check("imm", out_imm, d.imm);
      check("rs1", 64'(out_rs1), 64'(oe.instr[19:15]));
      check("rs2", 64'(out_rs2), 64'(oe.instr[24:20]));
      check("rd", 64'(out_rd), 64'(oe.instr[11:7]));
      check("func3", 64'(out_func3), 64'(oe.instr[14:12]));
      check("rs1_en", 64'(out_rs1_en), 64'(d.rs1));
      check("rs2_en", 64'(out_rs2_en), 64'(d.rs2));
      check("rd_wen", 64'(out_rd_wen), 64'(d.wen));
      check("op2_imm", 64'(out_op2_is_imm), 64'(d.op2));
      check("word", 64'(out_word), 64'(d.word));
      check("illegal", 64'(out_illegal), 64'(d.ill));
      check("class", 64'(out_class), 64'(d.cls));
    end
    if (rst_n) begin
      if (flush) begin
        q.delete(); ov = 1'b0;
      end else begin
        if (ov && out_ready) delivered++;
        do_load = (q.size() > 0) && (!ov || out_ready);
        accept  = in_valid && (q.size() < DEPTH);
        if (do_load) begin oe = q.pop_front(); ov = 1'b1; end
        else if (out_ready) ov = 1'b0;
        if (accept) q.push_back(ent_t'{pc: in_pc, instr: in_instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = 64'd0; in_instr = 32'd0;
    v32 = 1'b0; rdy32 = 1'b1; pc32 = 32'd0; instr32 = 32'd0;
    cycle(); cycle(); cycle();
    rst_n = 1'b1;

    // addi x5,x0,-1: two edges from push to presentation
    in_valid = 1'b1; in_pc = 64'h8000_0000; in_instr = 32'hFFF0_0293;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("lat_rd", 64'(out_rd), 64'd5);
    check("lat_wen", 64'(out_rd_wen), 64'd1);
    check("lat_class", 64'(out_class), 64'h01);
    cycle();

    // store, nop and all-zero word
    in_valid = 1'b1; in_pc = 64'h2000; in_instr = 32'h0020_A423; cycle();
    in_pc = 64'h2004; in_instr = 32'h0000_0013; cycle();
    check("sw_wen", 64'(out_rd_wen), 64'd0);
    check("sw_imm", out_imm, 64'd8);
    check("sw_class", 64'(out_class), 64'h04);
    in_pc = 64'h2008; in_instr = 32'h0000_0000; cycle();
    check("nop_wen", 64'(out_rd_wen), 64'd0);
    check("nop_class", 64'(out_class), 64'h01);
    in_valid = 1'b0; cycle();
    check("zero_illegal", 64'(out_illegal), 64'd1);
    check("zero_class", 64'(out_class), 64'h00);
    cycle(); cycle();

    // backpressure: DEPTH+1 accepted, further offers refused, then ordered drain
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      in_valid = 1'b1; in_pc = 64'h1000 + 64'(4 * i); in_instr = 32'h0010_0093 | (32'(i) << 20);
      cycle();
    end
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1; base = delivered;
    for (int i = 0; i < DEPTH + 3; i++) cycle();
    check("bp_delivered", 64'(delivered - base), 64'(DEPTH + 1));

    // streaming with pointer wrap
    base = delivered;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      in_valid = 1'b1; in_pc = 64'h3000 + 64'(4 * i); in_instr = rand_instr();
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("stream_delivered", 64'(delivered - base), 64'(3 * DEPTH));

    // flush with count=3, out_valid=1, in_valid=1
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 64'h4000 + 64'(4 * i); in_instr = 32'h0000_0013;
      cycle();
    end
    check("preflush_count", 64'(count), 64'd3);
    check("preflush_valid", 64'(out_valid), 64'd1);
    flush = 1'b1; in_pc = 64'h4010; cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1; base = delivered;
    for (int i = 0; i < 4; i++) cycle();
    check("flush_delivered", 64'(delivered - base), 64'd0);

    // addw and ld: illegal on XLEN=32, legal on XLEN=64
    in_valid = 1'b1; v32 = 1'b1; in_pc = 64'h5000; pc32 = 32'h5000;
    in_instr = 32'h0020_81BB; instr32 = 32'h0020_81BB; cycle();
    in_pc = 64'h5004; pc32 = 32'h5004; in_instr = 32'h0000_B183; instr32 = 32'h0000_B183; cycle();
    in_valid = 1'b0; v32 = 1'b0;
    check("addw32_valid", 64'(ov32), 64'd1);
    check("addw32_illegal", 64'(ill32), 64'(ref_dec(32'h0020_81BB, 1'b1).ill));
    check("addw32_wen", 64'(wen32), 64'd0);
    check("addw64_illegal", 64'(out_illegal), 64'd0);
    cycle();
    check("ld32_illegal", 64'(ill32), 64'd1);
    check("ld32_wen", 64'(wen32), 64'd0);
    check("ld64_illegal", 64'(out_illegal), 64'd0);
    cycle(); cycle();

    // random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      in_pc     = {$urandom, $urandom};
      in_instr  = rand_instr();
      if (i == 300) rst_n = 1'b0;
      if (i == 303) rst_n = 1'b1;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) cycle();
    check("drained_count", 64'(count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/idu_queue.md
IDU_QUEUE -- requirements
Module: idu_queue

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have ports in_valid input 1, in_ready output 1, in_pc input XLEN, in_instr input 32: fetch-side handshake.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-008 SHALL have ports out_pc output XLEN, out_imm output XLEN, out_rs1/out_rs2/out_rd output 5 each, out_func3 output 3.
REQ-009 SHALL have ports out_rs1_en, out_rs2_en, out_rd_wen, out_op2_is_imm, out_word, out_illegal output 1 each.
REQ-010 SHALL have port out_class output 7, one-hot {sys, csr, jump, branch, store, load, alu}, MSB first.
REQ-011 SHALL have port count output $clog2(DEPTH+1), queue occupancy.

Function
REQ-012 SHALL store {pc, instr} in a DEPTH-entry circular FIFO; push when in_valid & in_ready.
REQ-013 SHALL drive in_ready = (count < DEPTH) & ~flush; in_ready SHALL NOT depend on out_ready.
REQ-014 SHALL hold one output register stage; load when count>0 & (~out_valid | out_ready), popping the head in the same edge.
REQ-015 SHALL decode combinationally from the FIFO head; all out_* fields are registered.
REQ-016 SHALL give latency 2: instruction pushed at edge N is presented with out_valid=1 after edge N+1 when queue and output stage are empty.
REQ-017 SHALL hold all out_* stable while out_valid & ~out_ready.
REQ-018 SHALL wrap read/write pointers modulo DEPTH; count = pushes - pops, with push and pop in one edge leaving count unchanged.
REQ-019 SHALL give flush priority over push, pop and load: at the flushing edge count, pointers and out_valid go to 0; the in_valid of that cycle is dropped.
REQ-020 SHALL produce imm by type, sign-extended from instr[31] to XLEN: I (OP-IMM, OP-IMM-32, LOAD, JALR), S, B, U (bits 31:12 then 12 zeros), J; CSR-immediate forms SHALL give zero-extended instr[19:15]; other types SHALL give 0.
REQ-021 SHALL set out_op2_is_imm for I, S, U, J types; out_word for OP-32/OP-IMM-32.
REQ-022 SHALL set out_rs1_en = 0 for U/J types; out_rs2_en = 1 only for R, OP-32, S, B types.
REQ-023 SHALL set out_rd_wen = 0 for store, branch, fence, ecall, ebreak, mret, illegal, or rd==0.
REQ-024 SHALL set out_illegal and out_class=0 for: instr[1:0]!=2'b11; unlisted opcode; instr==0; R/OP-32 funct7 other than 0000000/0100000; and, when XLEN=32, OP-32, OP-IMM-32, LD, LWU, SD, and shift immediates with instr[25]=1.
REQ-025 SHALL pass out_pc unchanged from the queued pc and out_rs1/rs2/rd/func3 as raw fields even when illegal.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force count, both pointers, out_valid and every out_* data field to 0.
REQ-027 SHALL NOT require FIFO storage contents to be reset; in_ready SHALL be 1 during and after reset unless flush=1.
REQ-028 SHALL discard any transaction in flight when rst_n asserts mid-operation; first push after deassertion behaves as REQ-016.

Verification
REQ-029 SHALL cover: push addi x5,x0,-1 (0xFFF00293) at pc 0x80000000 -> 2 edges later out_valid=1, out_imm=0xFFFF_FFFF_FFFF_FFFF, out_rd=5, out_rd_wen=1, out_class=0000001.
REQ-030 SHALL cover: out_ready=0, push DEPTH+1 instrs -> count=DEPTH (1 held in output stage), in_ready=0, extra in_valid not accepted; release out_ready -> in-order delivery, no loss.
REQ-031 SHALL cover: continuous push and out_ready=1 over 3*DEPTH instrs -> one out per cycle, pointer wrap, pc sequence intact.
REQ-032 SHALL cover: flush with count=3, out_valid=1, in_valid=1 -> next cycle count=0, out_valid=0, flushed instrs never emitted.
REQ-033 SHALL cover: XLEN=32, push addw (0x002081BB) and ld (0x0000B183) -> out_illegal=1, out_rd_wen=0; XLEN=64 same -> legal.
REQ-034 SHALL cover: push sw x2,8(x1) (0x0020A423) and addi x0,x0,0 -> store rd_wen=0, imm=8; nop rd_wen=0, class alu.
